tow_round_ctrl: RTL and testbench
=================================

# tow_round_ctrl

Round sequencer for the Tug-of-War game. Drives the push-button latch block's `clr` input, inserts a pseudo-random "get ready" delay before each round, samples the latch block's `push`/`tie`/`right` outputs, and moves a rope-position register one step per decided round. It declares fouls for early presses and a winner when the rope reaches either end. It sits between the raw buttons/latch block and the LED display driver.

## Interface

Parameters:
- `NUM_POS`, 9: number of rope positions. Must be odd and ≥3. Centre is `(NUM_POS-1)/2`.
- `DELAY_MIN`, 16'd50000: minimum WAIT length in cycles.
- `DELAY_MASK`, 16'h7FFF: AND-mask applied to the LFSR-derived random extension.

Ports:
- `clk`, input, 1: system clock. Single clock domain.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: level. Begins a match from IDLE or WIN.
- `pbl`, input, 1: raw left button. Used for release and foul detection.
- `pbr`, input, 1: raw right button.
- `push`, input, 1: from the latch block. A press was latched.
- `tie`, input, 1: from the latch block. Both buttons pressed together.
- `right`, input, 1: from the latch block. The right player was first.
- `clr`, output, 1: to the latch block. Holds the latches cleared.
- `go`, output, 1: "pull now" lamp.
- `pos`, output, `$clog2(NUM_POS)`: rope position. 0 is the left end; `NUM_POS-1` is the right end.
- `leds`, output, `NUM_POS`: one-hot decode of `pos`, with bit `pos` set.
- `foul`, output, 1: one-cycle pulse when an early press is penalised.
- `winner_valid`, output, 1: high in the WIN state.
- `winner_right`, output, 1: valid only when `winner_valid` is high. 1 means the right player won.

## Operation

All outputs are registered. Reset values:
- state = IDLE
- `pos` = centre, so `leds` has only the centre bit set
- `clr` = 1
- `go` = 0, `foul` = 0, `winner_valid` = 0, `winner_right` = 0
- LFSR = 8'hA5

LFSR:
- 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
- Advances every cycle in every state except reset.
- Never all-zero.

State machine:
- **IDLE**: `clr`=1, `go`=0. When `start`=1: set `pos` to centre and go to RELEASE.
- **RELEASE**: `clr`=1. When `pbl`=0 and `pbr`=0 in the same cycle:
  - load `cnt` = `DELAY_MIN` + ({LFSR,LFSR} & `DELAY_MASK`), computed as 16-bit with wrap;
  - go to WAIT.
- **WAIT**: `clr`=1, `go`=0.
  - If `pbl` or `pbr` is high, go to FOUL. Foul has priority over `cnt`=0.
  - Otherwise, if `cnt`=0, go to GO.
  - Otherwise decrement `cnt`.
- **GO**: `clr`=0, `go`=1. When `push`=1: capture `tie` and `right`, then go to SCORE. There is no timeout.
- **SCORE** (1 cycle): `clr`=1, `go`=0.
  - Captured `tie`=1: `pos` unchanged.
  - Else captured `right`=1: `pos`+1.
  - Else: `pos`−1.
  - Next state is CHECK.
- **FOUL** (1 cycle): `foul`=1, `clr`=1. The penalty moves the rope away from the offender:
  - `pbl` only: `pos`+1.
  - `pbr` only: `pos`−1.
  - Both: no move.
  - Button levels are those sampled on the cycle WAIT exited. Next state is CHECK.
- **CHECK** (1 cycle): if `pos`=0 or `pos`=`NUM_POS-1`, go to WIN; otherwise go to RELEASE.
- **WIN**: `clr`=1, `winner_valid`=1, `winner_right` = (`pos`==`NUM_POS-1`). `pos` is frozen.
  - When `start`=1: `pos` = centre, clear `winner_valid`, go to RELEASE.

Rules:
- `pos` arithmetic never wraps. The ±1 updates cannot exceed the ends, because CHECK enters WIN at either end before another update can occur.
- `start` is ignored in every state except IDLE and WIN.
- `rst` asserted in any state returns all outputs to their reset values on the next edge.

## Timing

- `clr` falls on the edge that enters GO. `go` rises on the same edge.
- `push` sampled high in GO at edge N:
  - SCORE at N+1;
  - `clr`=1 and `go`=0 from N+1;
  - new `pos`/`leds` visible from N+2;
  - CHECK at N+2;
  - RELEASE or WIN from N+3.
- The latch block's `push` is gated by `clr`, so no press can register outside GO.
- WAIT length is `cnt`+1 cycles, counted from the RELEASE exit to GO entry.
- `foul` is high for exactly 1 cycle, in the FOUL state.

## Test plan

Bench parameters for all scenarios: `NUM_POS`=9, `DELAY_MIN`=4, `DELAY_MASK`=16'h0003.

- **Reset:**
  - Stimulus: assert `rst` for 2 cycles.
  - Required: `pos`=4, `leds`=9'h010, `clr`=1, `go`=0, `winner_valid`=0. `start` while `rst`=1 has no effect.
- **Right win of a round:**
  - Stimulus: `start`; wait for `go`=1; drive `push`=1, `right`=1, `tie`=0.
  - Required: `pos`=5 two cycles later; `clr` high again one cycle after `push`.
  - Also required: WAIT length is between 5 and 8 cycles.
- **Tie:**
  - Stimulus: in GO, drive `push`=1, `tie`=1.
  - Required: `pos` stays 4; FSM returns to RELEASE and waits for both buttons released.
- **Foul:**
  - Stimulus: `pbl`=1 two cycles into WAIT.
  - Required: `foul` pulses for 1 cycle; `pos` 4→5; `go` never asserts in that round.
  - Stimulus: `pbl`=`pbr`=1 together in WAIT.
  - Required: `foul` pulses; `pos` unchanged.
- **Match to win:**
  - Stimulus: 4 consecutive left wins from centre.
  - Required: `pos` 4→0; `winner_valid`=1, `winner_right`=0; `pos` stays frozen; further `push` is ignored.
  - Stimulus: then `start`.
  - Required: `pos`=4, `winner_valid`=0.
- **Release gating and reset mid-round:**
  - Stimulus: hold `pbr`=1 after SCORE.
  - Required: FSM stays in RELEASE with `clr`=1.
  - Stimulus: `rst` asserted during GO.
  - Required: IDLE, `go`=0, `clr`=1 the next cycle.

Source files
------------

// File: rtl/tow_round_ctrl.sv
// tow_round_ctrl: Tug-of-War round sequencer with random delay, foul and win detection
module tow_round_ctrl #(
  parameter int          NUM_POS    = 9,
  parameter logic [15:0] DELAY_MIN  = 16'd50000,
  parameter logic [15:0] DELAY_MASK = 16'h7FFF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       pbl,
  input  logic                       pbr,
  input  logic                       push,
  input  logic                       tie,
  input  logic                       right,
  output logic                       clr,
  output logic                       go,
  output logic [$clog2(NUM_POS)-1:0] pos,
  output logic [NUM_POS-1:0]         leds,
  output logic                       foul,
  output logic                       winner_valid,
  output logic                       winner_right
);
  localparam int PW = $clog2(NUM_POS);
  localparam logic [PW-1:0] MID  = PW'((NUM_POS - 1) / 2);
  localparam logic [PW-1:0] LAST = PW'(NUM_POS - 1);
  typedef enum logic [2:0] {IDLE, RELEASE, WAIT, GO, SCORE, FOUL, CHECK, WIN} state_t;
  state_t st;
  logic [7:0] lfsr;
  logic [15:0] cnt;
  logic t_q, r_q, bl, br, up, dn;
  logic [PW-1:0] pn;
  function automatic logic [NUM_POS-1:0] dec(input logic [PW-1:0] p);
    dec = '0;
    dec[p] = 1'b1;
  endfunction
  always_comb begin
    up = st == SCORE ? (!t_q && r_q) : (bl && !br);
    dn = st == SCORE ? (!t_q && !r_q) : (br && !bl);
    pn = up ? pos + PW'(1) : dn ? pos - PW'(1) : pos;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      pos <= MID;
      leds <= dec(MID);
      clr <= 1'b1;
      go <= 1'b0;
      foul <= 1'b0;
      winner_valid <= 1'b0;
      winner_right <= 1'b0;
      lfsr <= 8'hA5;
      cnt <= '0;
      t_q <= 1'b0;
      r_q <= 1'b0;
      bl <= 1'b0;
      br <= 1'b0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      foul <= 1'b0;
      case (st)
        IDLE, WIN: if (start) begin
          st <= RELEASE;
          pos <= MID;
          leds <= dec(MID);
          winner_valid <= 1'b0;
          winner_right <= 1'b0;
        end
        RELEASE: if (!pbl && !pbr) begin
          st <= WAIT;
          cnt <= DELAY_MIN + ({lfsr, lfsr} & DELAY_MASK);
        end
        WAIT: if (pbl || pbr) begin
          st <= FOUL;
          foul <= 1'b1;
          bl <= pbl;
          br <= pbr;
        end else if (cnt == '0) begin
          st <= GO;
          clr <= 1'b0;
          go <= 1'b1;
        end else begin
          cnt <= cnt - 16'd1;
        end
        GO: if (push) begin
          st <= SCORE;
          clr <= 1'b1;
          go <= 1'b0;
          t_q <= tie;
          r_q <= right;
        end
        SCORE, FOUL: begin
          st <= CHECK;
          pos <= pn;
          leds <= dec(pn);
        end
        CHECK: if (pos == '0 || pos == LAST) begin
          st <= WIN;
          winner_valid <= 1'b1;
          winner_right <= pos == LAST;
        end else begin
          st <= RELEASE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tow_round_ctrl.sv
// tb_tow_round_ctrl: directed self-checking bench for tow_round_ctrl
module tb_tow_round_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0, start = 1'b0, pbl = 1'b0, pbr = 1'b0, push = 1'b0, tie = 1'b0, right = 1'b0;
  logic clr, go, foul, winner_valid, winner_right;
  logic [3:0] pos;
  logic [8:0] leds;
  int checks = 0, errors = 0;
  int n;
  logic seen_go, seen_foul, seen_noclr;
  tow_round_ctrl #(.NUM_POS(9), .DELAY_MIN(16'd4), .DELAY_MASK(16'h0003)) dut (
    .clk(clk), .rst(rst), .start(start), .pbl(pbl), .pbr(pbr), .push(push), .tie(tie),
    .right(right), .clr(clr), .go(go), .pos(pos), .leds(leds), .foul(foul),
    .winner_valid(winner_valid), .winner_right(winner_right)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic begin_match();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_go(output int cyc);
    cyc = 0;
    while (!go && cyc < 40) begin
      tick();
      cyc++;
    end
    check("go_timeout", go, 1);
  endtask
  task automatic round(input logic t, input logic r);
    int c;
    wait_go(c);
    push = 1'b1;
    tie = t;
    right = r;
    tick();
    push = 1'b0;
    tie = 1'b0;
    right = 1'b0;
    tick();
    tick();
  endtask
  initial begin
    start = 1'b1;
    do_reset();
    start = 1'b0;
    check("rst_pos", pos, 4);
    check("rst_leds", leds, 9'h010);
    check("rst_clr", clr, 1);
    check("rst_go", go, 0);
    check("rst_wv", winner_valid, 0);
    check("rst_foul", foul, 0);
    tick();
    tick();
    check("idle_go", go, 0);
    begin_match();
    wait_go(n);
    check("wait_len", (n >= 6 && n <= 9), 1);
    check("go_clr", clr, 0);
    push = 1'b1;
    right = 1'b1;
    tick();
    push = 1'b0;
    right = 1'b0;
    check("score_clr", clr, 1);
    check("score_go", go, 0);
    check("score_pos_old", pos, 4);
    pbr = 1'b1;
    tick();
    check("right_pos", pos, 5);
    check("right_leds", leds, 9'h020);
    seen_go = 1'b0;
    seen_noclr = 1'b0;
    seen_foul = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen_go |= go;
      seen_foul |= foul;
      seen_noclr |= !clr;
    end
    check("hold_go", seen_go, 0);
    check("hold_clr", seen_noclr, 0);
    check("hold_foul", seen_foul, 0);
    pbr = 1'b0;
    do_reset();
    begin_match();
    round(1'b1, 1'b0);
    check("tie_pos", pos, 4);
    pbl = 1'b1;
    seen_go = 1'b0;
    seen_foul = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen_go |= go;
      seen_foul |= foul;
    end
    check("tie_release_go", seen_go, 0);
    check("tie_release_foul", seen_foul, 0);
    pbl = 1'b0;
    wait_go(n);
    do_reset();
    begin_match();
    tick();
    tick();
    pbl = 1'b1;
    tick();
    pbl = 1'b0;
    check("foul_l_pulse", foul, 1);
    check("foul_l_go", go, 0);
    check("foul_l_pos_old", pos, 4);
    tick();
    check("foul_l_end", foul, 0);
    check("foul_l_pos", pos, 5);
    check("foul_l_leds", leds, 9'h020);
    tick();
    check("foul_l_go2", go, 0);
    tick();
    tick();
    pbl = 1'b1;
    pbr = 1'b1;
    tick();
    pbl = 1'b0;
    pbr = 1'b0;
    check("foul_b_pulse", foul, 1);
    tick();
    check("foul_b_end", foul, 0);
    check("foul_b_pos", pos, 5);
    do_reset();
    begin_match();
    for (int i = 0; i < 4; i++) begin
      round(1'b0, 1'b0);
      check("left_pos", pos, 3 - i);
    end
    check("win_valid", winner_valid, 1);
    check("win_right", winner_right, 0);
    check("win_leds", leds, 9'h001);
    push = 1'b1;
    right = 1'b1;
    tick();
    tick();
    tick();
    push = 1'b0;
    right = 1'b0;
    check("win_frozen", pos, 0);
    check("win_hold", winner_valid, 1);
    check("win_nogo", go, 0);
    begin_match();
    check("restart_pos", pos, 4);
    check("restart_wv", winner_valid, 0);
    wait_go(n);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_go", go, 0);
    check("midrst_clr", clr, 1);
    check("midrst_pos", pos, 4);
    seen_go = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen_go |= go;
    end
    check("midrst_idle", seen_go, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
